seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 101 ++++++++++
 tb/tb_seq_divider.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: 32-bit restoring sequential divider, one quotient bit per cycle.
// Ports:
//   clk        - clock, rising edge
//   resetN     - asynchronous active-low reset
//   start      - request a division (accepted only when idle)
//   src1, src2 - dividend and divisor, captured on the accepting edge
//   quotient   - registered quotient, held until the next result
//   remainder  - registered remainder, held until the next result
//   busy       - high from accept until the result is delivered
//   done       - one-cycle pulse when quotient/remainder become valid
//   divByZero  - set with done when the divisor was zero, cleared on accept
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's-complement signed operands.
module seq_divider (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        divByZero
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] a, b, r, qv, rv;
    logic [32:0] sh;
    logic [33:0] df;
    // a holds the dividend and collects quotient bits as they shift in
    assign sh = {r, a[31]};
    // bit 33 is the carry out of sh - b: set means no borrow
    assign df = {1'b0, sh} + {1'b0, ~{1'b0, b}} + 34'd1;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic        neg_q, neg_r;
    logic [31:0] m1, m2, mag_r;
    assign m1 = src1[31] ? -src1 : src1;
    assign m2 = src2[31] ? -src2 : src2;
    // on divide-by-zero a still holds |src1|, so negation restores src1
    assign mag_r = (b == '0) ? a : r;
    assign qv = (b == '0) ? '1 : (neg_q ? -a : a);
    assign rv = neg_r ? -mag_r : mag_r;
`else
    assign qv = (b == '0) ? '1 : a;
    assign rv = (b == '0) ? a : r;
`endif
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            cnt       <= '0;
            a         <= '0;
            b         <= '0;
            r         <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            divByZero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    a     <= m1;
                    b     <= m2;
                    neg_q <= src1[31] ^ src2[31];
                    neg_r <= src1[31];
`else
                    a     <= src1;
                    b     <= src2;
`endif
                    r         <= '0;
                    cnt       <= '0;
                    busy      <= 1'b1;
                    divByZero <= 1'b0;
                    state     <= (src2 == '0) ? FINISH : RUN;
                end
                RUN: begin
                    a     <= {a[30:0], df[33]};
                    r     <= df[33] ? df[31:0] : sh[31:0];
                    cnt   <= cnt + 6'd1;
                    state <= (cnt == 6'd31) ? FINISH : RUN;
                end
                FINISH: begin
                    quotient  <= qv;
                    remainder <= rv;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    divByZero <= (b == '0);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed bench for seq_divider with a cycle-level reference model.
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src1 = '0, src2 = '0;
    logic [31:0] quotient, remainder;
    logic        busy, done, divByZero;
    int tests = 0, fails = 0;

    seq_divider dut (
        .clk(clk), .resetN(resetN), .start(start), .src1(src1), .src2(src2),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
        .divByZero(divByZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the division rules.
    function automatic logic [63:0] ref_div(input logic [31:0] s1, input logic [31:0] s2);
`ifdef SEQ_DIVIDER_SIGNED_EN
        logic signed [31:0] sa, sb, q, r;
        sa = s1;
        sb = s2;
        if (s2 == 0) return {32'hFFFFFFFF, s1};
        if (s1 == 32'h80000000 && s2 == 32'hFFFFFFFF) return {32'h80000000, 32'h0};
        q = sa / sb;
        r = sa % sb;
        return {q, r};
`else
        if (s2 == 0) return {32'hFFFFFFFF, s1};
        return {s1 / s2, s1 % s2};
`endif
    endfunction

    // Timing model: accept on an edge when idle, result due 33 edges later
    // (1 edge later for a zero divisor); results held between deliveries.
    int cyc = 0, due = 0;
    bit pend = 0;
    bit [31:0] mq = 0, mr = 0, eq = 0, er = 0;
    bit mdz = 0, edz = 0;
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cyc = 0; pend = 0; mq = 0; mr = 0; mdz = 0;
        end else begin
            cyc = cyc + 1;
            if (pend && cyc == due) begin
                mq = eq; mr = er; mdz = edz;
            end
            if (start && !(pend && cyc <= due)) begin
                pend = 1;
                due = cyc + ((src2 == 0) ? 1 : 33);
                {eq, er} = ref_div(src1, src2);
                edz = (src2 == 0);
                mdz = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_done", done, pend && cyc == due);
        check("cyc_busy", busy, pend && cyc < due);
        check("cyc_quotient", quotient, mq);
        check("cyc_remainder", remainder, mr);
        check("cyc_divByZero", divByZero, mdz);
    end

    task automatic launch(input logic [31:0] s1, input logic [31:0] s2, output int k);
        @(negedge clk);
        #1 src1 = s1; src2 = s2; start = 1'b1;
        @(negedge clk);
        k = cyc;
        #1 start = 1'b0; src1 = $urandom; src2 = $urandom;
    endtask

    task automatic wait_done(input string nm, input int k, input int lat,
                             input logic [31:0] q, input logic [31:0] r, input logic dz);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check({nm, "_done_seen"}, seen, 1);
        check({nm, "_latency"}, cyc - k + 1, lat);
        check({nm, "_quotient"}, quotient, q);
        check({nm, "_remainder"}, remainder, r);
        check({nm, "_divByZero"}, divByZero, dz);
        check({nm, "_busy_at_done"}, busy, 0);
    endtask

    task automatic run_op(input string nm, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [31:0] q, input logic [31:0] r, input logic dz);
        int k;
        launch(s1, s2, k);
        wait_done(nm, k, dz ? 2 : 34, q, r, dz);
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        check("rst_quotient", quotient, 0);
        check("rst_busy", busy, 0);
        #1 resetN = 1'b1;

        run_op("d100_7", 100, 7, 14, 2, 0);
        run_op("max_by_1", 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 0);
        run_op("d5_9", 5, 9, 0, 5, 0);
        run_op("div_zero", 1234, 0, 32'hFFFFFFFF, 1234, 1);

        // start with other operands mid-run must not disturb the result
        launch(100, 7, k);
        repeat (9) @(negedge clk);
        #1 src1 = 999; src2 = 3; start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        wait_done("ignore_mid", k, 34, 14, 2, 0);

        // start held through FINISH: taken again only on the following edge
        @(negedge clk);
        #1 src1 = 50; src2 = 5; start = 1'b1;
        @(negedge clk);
        k = cyc;
        wait_done("hold1", k, 34, 10, 0, 0);
        @(negedge clk);
        k = cyc;
        check("hold_reaccept_busy", busy, 1);
        #1 start = 1'b0;
        wait_done("hold2", k, 34, 10, 0, 0);

        // reset in the middle of a run
        launch(1000, 3, k);
        repeat (20) @(negedge clk);
        #1 resetN = 1'b0;
        #1;
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (2) @(negedge clk);
        #1 resetN = 1'b1;
        repeat (40) @(negedge clk);
        run_op("after_rst", 1000, 3, 333, 1, 0);

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op("s_m7_2", 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
        run_op("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0);
        run_op("s_m20_0", 32'hFFFFFFEC, 0, 32'hFFFFFFFF, 32'hFFFFFFEC, 1);
`else
        run_op("u_big_2", 32'hFFFFFFF9, 2, 32'h7FFFFFFC, 1, 0);
        run_op("u_min_max", 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0);
`endif
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
